// File: rtl/common_pkg.sv
// common: shared multiply/divide op, state and iteration definitions (muldiv_unit divide support via MULDIV_DIV_EN)
package common;
    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } muldiv_op_t;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } muldiv_state_t;
    localparam int MULDIV_ITER = 32;
endpackage

// File: rtl/muldiv_negate.sv
// muldiv_negate: conditional two's-complement, used for operand magnitudes and result sign fixup
module muldiv_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] x,
    input  logic         neg,
    output logic [W-1:0] y
);
    assign y = neg ? -x : x;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-cycle shift-add multiplier / restoring divider; define MULDIV_DIV_EN for divide support
module muldiv_unit
    import common::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        flush,
    input  muldiv_op_t  op,
    input  logic [31:0] src0,
    input  logic [31:0] src1,
    output logic [31:0] result,
    output logic        done,
    output logic        busy,
    output logic        stall
);
    muldiv_state_t state;
    muldiv_op_t    op_q;
    logic [31:0]   a_q, b_q, abs0, abs1, special_res, fix_res;
    logic [63:0]   acc, acc_next, fix_in, fix_out;
    logic [32:0]   mul_sum;
    logic [4:0]    cnt;
    logic          neg_q, sa, sb, special;
`ifdef MULDIV_DIV_EN
    logic [32:0]   div_sh;
    logic [31:0]   div_dif;
    logic          div_restore;
`endif
    muldiv_negate #(.W(32)) u_abs0 (.x(src0), .neg(sa), .y(abs0));
    muldiv_negate #(.W(32)) u_abs1 (.x(src1), .neg(sb), .y(abs1));
    muldiv_negate #(.W(64)) u_fix (.x(fix_in), .neg(neg_q), .y(fix_out));
`ifdef MULDIV_DIV_EN
    assign fix_res = (op_q[2] || op_q == MUL) ? fix_out[31:0] : fix_out[63:32];
`else
    assign fix_res = (op_q == MUL) ? fix_out[31:0] : fix_out[63:32];
`endif
    assign busy  = state != IDLE;
    assign done  = state == DONE && !flush;
    assign stall = (start && state == IDLE && !flush) || (busy && !done);
    // operand signs, one iteration of the datapath, special-case detection and fixup input
    always_comb begin
        sa = (op == MULH || op == MULHSU || op == DIV || op == REM) && src0[31];
        sb = (op == MULH || op == DIV || op == REM) && src1[31];
        mul_sum = {1'b0, acc[63:32]} + (b_q[0] ? {1'b0, a_q} : 33'd0);
`ifdef MULDIV_DIV_EN
        div_sh = {acc[63:32], a_q[31]};
        div_dif = div_sh[31:0] - b_q;
        div_restore = div_sh < {1'b0, b_q};
        acc_next = op_q[2] ? {div_restore ? div_sh[31:0] : div_dif, acc[30:0], ~div_restore}
                           : {mul_sum, acc[31:1]};
        special = op[2] && (src1 == '0 || ((op == DIV || op == REM) && src0 == 32'h8000_0000 && src1 == '1));
        special_res = (src1 == '0) ? (op[1] ? src0 : 32'hFFFF_FFFF) : (op[1] ? 32'd0 : 32'h8000_0000);
        fix_in = op_q[2] ? {32'd0, op_q[1] ? acc[63:32] : acc[31:0]} : acc;
`else
        acc_next = {mul_sum, acc[31:1]};
        special = op[2];
        special_res = 32'd0;
        fix_in = acc;
`endif
    end
    // FSM, iteration counter and operand/accumulator registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            op_q   <= MUL;
            a_q    <= '0;
            b_q    <= '0;
            neg_q  <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    op_q  <= op;
                    a_q   <= abs0;
                    b_q   <= abs1;
                    neg_q <= (op == REM) ? sa : sa ^ sb;
                    acc   <= '0;
                    cnt   <= '0;
                    if (special) result <= special_res;
                    state <= special ? DONE : CALC;
                end
                CALC: begin
                    acc   <= acc_next;
                    a_q   <= op_q[2] ? a_q << 1 : a_q;
                    b_q   <= op_q[2] ? b_q : b_q >> 1;
                    cnt   <= cnt + 5'd1;
                    state <= (cnt == 5'(MULDIV_ITER - 1)) ? FIXUP : CALC;
                end
                FIXUP: begin
                    result <= fix_res;
                    state  <= DONE;
                end
                DONE: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed plus randomized checks of muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
    import common::*;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    muldiv_op_t  op = MUL;
    logic [31:0] src0 = '0;
    logic [31:0] src1 = '0;
    logic [31:0] result;
    logic        done, busy, stall;
    int          n_cmp = 0;
    int          n_bad = 0;

    muldiv_unit dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op),
        .src0(src0), .src1(src1), .result(result), .done(done), .busy(busy), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // returns {special, value}: special means the op completes one cycle after start
    function automatic logic [32:0] model(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b);
        longint x, y;
        logic [63:0] p;
        int ia, ib;
        x = (o == MULH || o == MULHSU) ? longint'($signed(a)) : longint'({32'd0, a});
        y = (o == MULH) ? longint'($signed(b)) : longint'({32'd0, b});
        p = 64'(x * y);
        ia = int'(a);
        ib = int'(b);
        case (o)
            MUL:                return {1'b0, p[31:0]};
            MULH, MULHSU, MULHU: return {1'b0, p[63:32]};
            default: ;
        endcase
`ifdef MULDIV_DIV_EN
        if (b == 0) return {1'b1, (o == DIV || o == DIVU) ? 32'hFFFF_FFFF : a};
        if ((o == DIV || o == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return {1'b1, (o == DIV) ? 32'h8000_0000 : 32'd0};
        case (o)
            DIV:     return {1'b0, 32'(ia / ib)};
            REM:     return {1'b0, 32'(ia % ib)};
            DIVU:    return {1'b0, a / b};
            default: return {1'b0, a % b};
        endcase
`else
        return 33'h1_0000_0000;
`endif
    endfunction

    // issues an op in the current cycle (caller is at a negedge) and checks timing and result
    task automatic run(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b, input bit junk);
        logic [32:0] m;
        int lat, seen;
        logic [31:0] res_at_done;
        logic stall_at_done;
        m = model(o, a, b);
        lat = m[32] ? 1 : 34;
        seen = -1;
        res_at_done = 'x;
        stall_at_done = 1'bx;
        start = 1'b1; op = o; src0 = a; src1 = b;
        #1 check("stall_c0", 32'(stall), 32'd1);
        @(posedge clk);
        for (int c = 1; c <= 60 && seen < 0; c++) begin
            @(negedge clk);
            if (done) begin
                seen = c;
                res_at_done = result;
                stall_at_done = stall;
                start = 1'b0;
            end else if (junk) begin
                start = 1'b1;
                op = muldiv_op_t'(3'($urandom_range(0, 7)));
                src0 = $urandom;
                src1 = $urandom;
            end else begin
                start = 1'b0;
            end
        end
        check($sformatf("done_cycle op%0d", o), 32'(seen), 32'(lat));
        check($sformatf("result op%0d %h,%h", o, a, b), res_at_done, m[31:0]);
        check("stall_in_done", 32'(stall_at_done), 32'd0);
        @(negedge clk);
        check("busy_after", 32'(busy), 32'd0);
    endtask

    initial begin
        muldiv_op_t ro;
        logic [31:0] pool [4] = '{32'd0, 32'd1, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] ra, rb;
        repeat (2) @(negedge clk);
        check("rst_result", result, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        run(MUL, 32'd7, 32'hFFFF_FFFD, 1'b0);
        run(MULH, 32'h8000_0000, 32'h8000_0000, 1'b1);
        run(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run(DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run(REM, 32'hFFFF_FFF9, 32'd2, 1'b1);
        run(DIVU, 32'd100, 32'd7, 1'b0);
        run(REMU, 32'd100, 32'd7, 1'b0);
        run(DIVU, 32'd5, 32'd0, 1'b0);
        run(REM, 32'd5, 32'd0, 1'b1);
        run(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run(REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        // flush in cycle 10 of a MUL, then restart in cycle 11
        start = 1'b1; op = MUL; src0 = 32'd3; src1 = 32'd5;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        flush = 1'b1;
        #1 check("flush_done", 32'(done), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        check("flush_idle", 32'(busy), 32'd0);
        run(MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        // flush while in DONE suppresses the done pulse
        start = 1'b1; op = MUL; src0 = 32'd9; src1 = 32'd9;
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        flush = 1'b1;
        #1 check("flush_in_done", 32'(done), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        check("flush_done_idle", 32'(busy), 32'd0);
        // reset in cycle 20 of a long operation
`ifdef MULDIV_DIV_EN
        start = 1'b1; op = DIV; src0 = 32'd1000; src1 = 32'd3;
`else
        start = 1'b1; op = MULHU; src0 = 32'd1000; src1 = 32'd3;
`endif
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_result", result, 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        for (int i = 0; i < 40; i++) begin
            ro = muldiv_op_t'(3'($urandom_range(0, 7)));
            ra = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 3)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 3)] : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
            run(ro, ra, rb, 1'($urandom_range(0, 1)));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
